// File: rtl/evac_grid_engine_if.sv
// Load stream plus run control and status bundle for evac_grid_engine.
// The master side drives map beats and start, and the slave side reports progress.
interface evac_grid_engine_if #(
  parameter int W          = 16,
  parameter int H          = 16,
  parameter int DW         = 13,
  parameter int MAX_SWEEPS = 1023,
  parameter int PW         = $clog2(W*H+1),
  parameter int SW         = $clog2(MAX_SWEEPS+1)
);
  logic          load_valid;
  logic          load_ready;
  logic [2:0]    load_cell;
  logic [DW-1:0] load_dist;
  logic          start;
  logic          busy;
  logic          done;
  logic          stalled;
  logic          timeout;
  logic [PW-1:0] people_out;
  logic [PW-1:0] people_left;
  logic [SW-1:0] sweeps;

  modport master (
    output load_valid, load_cell, load_dist, start,
    input  load_ready, busy, done, stalled, timeout, people_out, people_left, sweeps
  );

  modport slave (
    input  load_valid, load_cell, load_dist, start,
    output load_ready, busy, done, stalled, timeout, people_out, people_left, sweeps
  );
endinterface

// File: rtl/evac_grid_engine.sv
// Evacuation cellular automaton: streams in a map and a distance field, then runs
// row-major sweeps that move each person toward the lowest-distance free neighbour.
module evac_grid_engine #(
  parameter int W          = 16,
  parameter int H          = 16,
  parameter int DW         = 13,
  parameter int MAX_SWEEPS = 1023,
  parameter int PW         = $clog2(W*H+1),
  parameter int SW         = $clog2(MAX_SWEEPS+1)
) (
  input logic               clk,
  input logic               rst,
  evac_grid_engine_if.slave bus
);
  localparam int N  = W * H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;

  localparam logic [2:0] CELL_EMPTY  = 3'b000;
  localparam logic [2:0] CELL_WALL   = 3'b001;
  localparam logic [2:0] CELL_EXIT   = 3'b010;
  localparam logic [2:0] CELL_PERSON = 3'b100;

  // Neighbour order N, S, W, E, NW, NE, SW, SE decides ties.
  localparam int DX [8] = '{0, 0, -1, 1, -1, 1, -1, 1};
  localparam int DY [8] = '{-1, 1, 0, 0, -1, -1, 1, 1};

  typedef enum logic [2:0] {IDLE, LOAD, READY, SCAN, EVAL, DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]    grid_q [N];
  logic [DW-1:0] dist_q [N];
  logic [N-1:0]  moved_q;
  logic [IW-1:0] idx_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [PW-1:0] peopleOut_q, peopleLeft_q;
  logic [SW-1:0] sweeps_q;
  logic          stalled_q, timeout_q, sweepMoved_q, startSeen_q;

  logic          loadFire, lastIdx, found, moveNow, runOver;
  logic [DW-1:0] bestDist;
  logic [IW-1:0] bestIdx;
  logic [2:0]    loadCode;

  assign loadFire = bus.load_valid && bus.load_ready;
  assign lastIdx  = (idx_q == IW'(N - 1));
  assign runOver  = (peopleLeft_q == '0) || !sweepMoved_q || (sweeps_q == SW'(MAX_SWEEPS));

  always_comb begin
    loadCode = CELL_WALL;
    if (bus.load_cell == CELL_EMPTY || bus.load_cell == CELL_EXIT || bus.load_cell == CELL_PERSON)
      loadCode = bus.load_cell;
  end

  always_comb begin : neighbourSearch
    int            nx;
    int            ny;
    logic [IW-1:0] nIdx;
    found    = 1'b0;
    bestDist = '0;
    bestIdx  = '0;
    nx       = 0;
    ny       = 0;
    nIdx     = '0;
    for (int k = 0; k < 8; k++) begin
      nx = int'(x_q) + DX[k];
      ny = int'(y_q) + DY[k];
      if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
        nIdx = IW'(ny * W + nx);
        if ((grid_q[nIdx] == CELL_EMPTY || grid_q[nIdx] == CELL_EXIT) &&
            (!found || dist_q[nIdx] < bestDist)) begin
          found    = 1'b1;
          bestDist = dist_q[nIdx];
          bestIdx  = nIdx;
        end
      end
    end
  end

  assign moveNow = (state_q == SCAN) && (grid_q[idx_q] == CELL_PERSON) && !moved_q[idx_q] &&
                   found && (bestDist < dist_q[idx_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (loadFire) state_d = LOAD;
      LOAD:       if (loadFire && lastIdx) state_d = READY;
      READY:      if (startSeen_q) state_d = SCAN;
      SCAN:       if (lastIdx) state_d = EVAL;
      EVAL:       state_d = runOver ? DONE : SCAN;
      default:    state_d = IDLE;
    endcase
  end

  assign bus.load_ready  = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);
  assign bus.busy        = (state_q == SCAN) || (state_q == EVAL);
  assign bus.done        = (state_q == DONE);
  assign bus.stalled     = stalled_q;
  assign bus.timeout     = timeout_q;
  assign bus.people_out  = peopleOut_q;
  assign bus.people_left = peopleLeft_q;
  assign bus.sweeps      = sweeps_q;

  // Grid updates land at the end of each visit, so the next visited cell sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        grid_q[i] <= CELL_EMPTY;
        dist_q[i] <= '0;
      end
      moved_q      <= '0;
      idx_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      peopleOut_q  <= '0;
      peopleLeft_q <= '0;
      sweeps_q     <= '0;
      stalled_q    <= 1'b0;
      timeout_q    <= 1'b0;
      sweepMoved_q <= 1'b0;
      startSeen_q  <= 1'b0;
    end else begin
      startSeen_q <= bus.start && (state_q == READY);
      case (state_q)
        IDLE, LOAD, DONE: begin
          if (loadFire && state_q == LOAD) begin
            grid_q[idx_q] <= loadCode;
            dist_q[idx_q] <= bus.load_dist;
            idx_q         <= idx_q + 1'b1;
            if (loadCode == CELL_PERSON) peopleLeft_q <= peopleLeft_q + 1'b1;
          end else if (loadFire) begin
            grid_q[0]    <= loadCode;
            dist_q[0]    <= bus.load_dist;
            idx_q        <= IW'(1);
            peopleOut_q  <= '0;
            sweeps_q     <= '0;
            stalled_q    <= 1'b0;
            timeout_q    <= 1'b0;
            peopleLeft_q <= (loadCode == CELL_PERSON) ? PW'(1) : '0;
          end
        end
        READY: begin
          if (startSeen_q) begin
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            moved_q      <= '0;
            sweepMoved_q <= 1'b0;
          end
        end
        SCAN: begin
          if (moveNow) begin
            grid_q[idx_q] <= CELL_EMPTY;
            sweepMoved_q  <= 1'b1;
            if (grid_q[bestIdx] == CELL_EXIT) begin
              peopleOut_q  <= peopleOut_q + 1'b1;
              peopleLeft_q <= peopleLeft_q - 1'b1;
            end else begin
              grid_q[bestIdx]  <= CELL_PERSON;
              moved_q[bestIdx] <= 1'b1;
            end
          end
          idx_q <= idx_q + 1'b1;
          if (x_q == XW'(W - 1)) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
          if (lastIdx) sweeps_q <= sweeps_q + 1'b1;
        end
        EVAL: begin
          if (peopleLeft_q != '0) begin
            if (!sweepMoved_q) begin
              stalled_q <= 1'b1;
            end else if (sweeps_q == SW'(MAX_SWEEPS)) begin
              timeout_q <= 1'b1;
            end else begin
              idx_q        <= '0;
              x_q          <= '0;
              y_q          <= '0;
              moved_q      <= '0;
              sweepMoved_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/evac_grid_engine.md
Name: evac_grid_engine

Overview:
- Parametrised successor to the fixed 64x64 evacuation automaton: grid size, distance width and sweep limit are parameters.
- Exits are taken from the loaded map (code 010), not hard-coded coordinates.
- Map and distance field are streamed in through a valid/ready port, then the block runs row-major sweeps, moving each person at most once per sweep toward the lowest-distance free neighbour.
- Reports evacuated/remaining people, sweep count, and a completion reason (all out, stalled, timeout).

Parameters:
- W, 16, grid columns (x = 0..W-1).
- H, 16, grid rows (y = 0..H-1).
- DW, 13, distance-field width in bits.
- MAX_SWEEPS, 1023, sweep limit before timeout.
- PW, $clog2(W*H+1), people counter width (derived).
- SW, $clog2(MAX_SWEEPS+1), sweep counter width (derived).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- load_valid, in, 1: load beat valid.
- load_ready, out, 1: block accepts a load beat.
- load_cell, in, 3: cell code. 000 empty, 001 wall, 010 exit, 100 person; other codes are treated as wall.
- load_dist, in, DW: distance value for the cell.
- start, in, 1: begin evacuation. Sampled only in READY.
- busy, out, 1: high in SCAN or EVAL.
- done, out, 1: high in DONE.
- stalled, out, 1: run ended with people remaining and no move in the last sweep.
- timeout, out, 1: run ended at MAX_SWEEPS.
- people_out, out, PW: persons evacuated this run.
- people_left, out, PW: persons still on the grid.
- sweeps, out, SW: completed sweeps this run.

Behaviour:
- Reset (async): state IDLE; grid cleared to 000; distances cleared to 0; all outputs 0 except load_ready=1.
- States: IDLE, LOAD, READY, SCAN, EVAL, DONE.
- Load handshake:
  - load_ready=1 in IDLE, LOAD and DONE.
  - A beat transfers when load_valid&&load_ready.
  - Beats arrive row-major: y=0,x=0 first; x increments fastest.
  - The first beat accepted in IDLE or DONE enters LOAD, resets the beat index, and clears people_out, sweeps, stalled, timeout, people_left.
  - Each person beat increments people_left.
  - Gaps in load_valid are allowed.
  - After beat W*H-1 is accepted, next state is READY. Any further beat is then ignored and load_ready=0.
- READY: start=1 -> SCAN with index 0, all per-cell moved bits cleared, sweep-move flag cleared. start outside READY is ignored.
- SCAN: visits one cell per cycle, index 0..W*H-1 row-major. For a cell holding a person whose moved bit is 0:
  - Candidates are the 8 neighbours in order N(y-1), S(y+1), W(x-1), E(x+1), NW, NE, SW, SE. A neighbour is eligible only if in bounds and its code is 000 or 010. There is no wrap-around at edges.
  - Pick the eligible candidate with the strictly smallest distance. On a tie, the earlier candidate in the order wins.
  - Move only if the chosen distance < own cell distance. Otherwise the person stays.
  - On a move: source becomes 000 and the sweep-move flag is set.
    - Target 010: target stays 010; people_out +1 and people_left -1 in the same cycle.
    - Target 000: target becomes 100 and its moved bit is set.
  - Field updates land on the clock edge ending the visit cycle, so the next visited cell sees the updated grid.
- After the index W*H-1 cycle -> EVAL, and sweeps increments on entry.
- EVAL (1 cycle), priority order:
  - people_left==0 -> DONE.
  - Else sweep-move flag==0 -> DONE with stalled=1.
  - Else sweeps==MAX_SWEEPS -> DONE with timeout=1.
  - Else -> SCAN: index 0, moved bits and flag cleared.
- Latency: with start sampled at edge t, a run of k sweeps asserts done from edge t + k*(W*H+1) + 1.
- DONE: outputs hold until the next load or reset. A people_left==0 map (no persons) finishes after 1 sweep with stalled=0.
- Counters never wrap. people_out+people_left equals the loaded person count at all times.
- rst mid-LOAD or mid-SCAN aborts immediately to reset values. No partial results are retained.

Test Plan:
- W=H=4, exit (0,0) dist 0, person (1,1) dist 1, other cells empty dist 5, start -> after 1 sweep: people_out=1, people_left=0, sweeps=1, done=1 at start+18 cycles, stalled=0, timeout=0.
- W=H=4, person (1,1) dist 3, all 8 neighbours wall -> sweeps=1, done, stalled=1, people_left=1, grid unchanged.
- Tie-break: person (1,1) dist 5, N (1,0) and E (2,1) empty dist 2, rest wall -> after sweep 1, (1,0)=100, (1,1)=000, (2,1)=000.
- Row 1, W=8, H=1 corridor: person x=7, dist 7..0 decreasing, exit x=0, MAX_SWEEPS=3:
  - After sweep 1 the person is at x=6 (moved bit blocks a second move).
  - Run ends with timeout=1, sweeps=3, person at x=4.
- Load with load_valid toggled every other cycle plus 3 extra beats after the last -> READY reached after exactly W*H accepted beats, extras ignored, people_left matches person count.
- Assert rst mid-SCAN of the first test, then reload and rerun -> all outputs 0 during reset, and the rerun gives the identical result to the first test.
